// File: rtl/beta_trace_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | beta_trace_capture : captures Beta CPU DM/RF write-backs into a FIFO      |
// | Optional macro BETA_TRACE_TIMESTAMP_EN adds a 32-bit trace_time field.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module beta_trace_capture #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       capture_en,
  input  logic                       halt,
  input  logic                       exported_wren_dm,
  input  logic [31:0]                exported_address_dm,
  input  logic [31:0]                exported_data_dm,
  input  logic                       exported_wren_rfw,
  input  logic [31:0]                exported_address_rfw,
  input  logic [31:0]                exported_data_rfw,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic                       trace_kind,
  output logic [31:0]                trace_address,
  output logic [31:0]                trace_data,
  output logic [$clog2(DEPTH):0]     trace_level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count,
  output logic                       frozen
`ifdef BETA_TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]                trace_time
`endif
);

  localparam int AW = $clog2(DEPTH);
`ifdef BETA_TRACE_TIMESTAMP_EN
  localparam int RW = 97;
`else
  localparam int RW = 65;
`endif

  logic [RW-1:0]    mem [DEPTH];
  logic [RW-1:0]    head;
  logic [RW-1:0]    last_q;
  logic [RW-1:0]    rec_dm;
  logic [RW-1:0]    rec_rf;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rf_slot;
  logic [AW+1:0]    free_slots;
  logic [AW+1:0]    free_after_dm;
  logic             dm_q;
  logic             rf_q;
  logic             ev_dm;
  logic             ev_rf;
  logic             push_dm;
  logic             push_rf;
  logic             pop;
  logic [1:0]       drops;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_next;

`ifdef BETA_TRACE_TIMESTAMP_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycle_q <= '0;
    else          cycle_q <= cycle_q + 32'd1;
  end

  assign rec_dm     = {cycle_q, 1'b0, exported_address_dm,  exported_data_dm};
  assign rec_rf     = {cycle_q, 1'b1, exported_address_rfw, exported_data_rfw};
  assign trace_time = trace_valid ? head[96:65] : last_q[96:65];
`else
  assign rec_dm = {1'b0, exported_address_dm,  exported_data_dm};
  assign rec_rf = {1'b1, exported_address_rfw, exported_data_rfw};
`endif

  always_comb begin
    trace_level   = wr_ptr - rd_ptr;
    trace_valid   = (trace_level != '0);
    pop           = trace_valid & trace_ready;
    ev_dm         = exported_wren_dm  & ~dm_q & capture_en & ~frozen;
    ev_rf         = exported_wren_rfw & ~rf_q & capture_en & ~frozen;
    // A same-cycle pop frees its slot before the pushes are placed.
    free_slots    = (AW+2)'(DEPTH) - {1'b0, trace_level} + {{(AW+1){1'b0}}, pop};
    push_dm       = ev_dm & (free_slots != '0);
    free_after_dm = free_slots - {{(AW+1){1'b0}}, push_dm};
    push_rf       = ev_rf & (free_after_dm != '0);
    rf_slot       = wr_ptr + {{AW{1'b0}}, push_dm};
    drops         = {1'b0, ev_dm & ~push_dm} + {1'b0, ev_rf & ~push_rf};
    drop_sum      = {1'b0, drop_count} + {{(CNT_W-1){1'b0}}, drops};
    drop_next     = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign trace_kind    = trace_valid ? head[64]    : last_q[64];
  assign trace_address = trace_valid ? head[63:32] : last_q[63:32];
  assign trace_data    = trace_valid ? head[31:0]  : last_q[31:0];

  always_ff @(posedge clk) begin
    if (push_dm) mem[wr_ptr[AW-1:0]]  <= rec_dm;
    if (push_rf) mem[rf_slot[AW-1:0]] <= rec_rf;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dm_q       <= 1'b0;
      rf_q       <= 1'b0;
      frozen     <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
      last_q     <= '0;
    end else begin
      dm_q   <= exported_wren_dm;
      rf_q   <= exported_wren_rfw;
      frozen <= frozen | halt;
      wr_ptr <= wr_ptr + {{AW{1'b0}}, push_dm} + {{AW{1'b0}}, push_rf};
      if (pop)          rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      // Keeps the last presented record on the outputs once the FIFO empties.
      if (trace_valid)  last_q <= head;
      if (drops != 2'd0) begin
        overflow   <= 1'b1;
        drop_count <= drop_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_beta_trace_capture.sv
`default_nettype none
// Scoreboard bench for beta_trace_capture: random and directed write-back
// traffic against a queue-based reference model.
module tb_beta_trace_capture;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n = 1'b0;
  logic              capture_en = 1'b0, halt = 1'b0;
  logic              wren_dm = 1'b0, wren_rf = 1'b0;
  logic [31:0]       addr_dm = '0, data_dm = '0, addr_rf = '0, data_rf = '0;
  logic              trace_ready = 1'b0;
  logic              trace_valid, trace_kind, overflow, frozen;
  logic [31:0]       trace_address, trace_data;
  logic [LW-1:0]     trace_level;
  logic [CNT_W-1:0]  drop_count;
`ifdef BETA_TRACE_TIMESTAMP_EN
  logic [31:0]       trace_time;
`endif

  beta_trace_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .capture_en(capture_en), .halt(halt),
    .exported_wren_dm(wren_dm), .exported_address_dm(addr_dm), .exported_data_dm(data_dm),
    .exported_wren_rfw(wren_rf), .exported_address_rfw(addr_rf), .exported_data_rfw(data_rf),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_kind(trace_kind),
    .trace_address(trace_address), .trace_data(trace_data), .trace_level(trace_level),
    .overflow(overflow), .drop_count(drop_count), .frozen(frozen)
`ifdef BETA_TRACE_TIMESTAMP_EN
    , .trace_time(trace_time)
`endif
  );

  typedef struct {
    logic        kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] tim;
  } rec_t;

  rec_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          m_level;
  logic        m_prev_dm, m_prev_rf, m_frozen, m_ovf;
  longint      m_drops;
  int unsigned m_time;

  task automatic chk(input string name, input longint act, input longint expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every accepted handshake must match the oldest expected record.
  always @(negedge clk) begin
    if (reset_n && trace_valid && trace_ready) begin
      rec_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got kind=%0d addr=%h data=%h, expected no record",
                 trace_kind, trace_address, trace_data);
      end else begin
        e = exp_q.pop_front();
        if (trace_kind !== e.kind || trace_address !== e.addr || trace_data !== e.data
`ifdef BETA_TRACE_TIMESTAMP_EN
            || trace_time !== e.tim
`endif
           ) begin
          fails++;
          $display("FAIL record: got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h time=%0d",
                   trace_kind, trace_address, trace_data, e.kind, e.addr, e.data, e.tim);
        end
      end
    end
  end

  // One clock cycle: drive inputs, advance the model to the coming edge, check status.
  task automatic step(input logic wdm, input logic [31:0] adm, input logic [31:0] ddm,
                      input logic wrf, input logic [31:0] arf, input logic [31:0] drf,
                      input logic rdy, input logic en, input logic hlt);
    logic ev_dm, ev_rf, pop;
    int   free, pushes, dropped;
    wren_dm = wdm; addr_dm = adm; data_dm = ddm;
    wren_rf = wrf; addr_rf = arf; data_rf = drf;
    trace_ready = rdy; capture_en = en; halt = hlt;

    ev_dm = wdm && !m_prev_dm && en && !m_frozen;
    ev_rf = wrf && !m_prev_rf && en && !m_frozen;
    m_prev_dm = wdm;
    m_prev_rf = wrf;
    pop  = rdy && (m_level > 0);
    free = DEPTH - m_level + (pop ? 1 : 0);
    pushes = 0; dropped = 0;
    if (ev_dm) begin
      if (free > 0) begin exp_q.push_back('{1'b0, adm, ddm, m_time}); free--; pushes++; end
      else dropped++;
    end
    if (ev_rf) begin
      if (free > 0) begin exp_q.push_back('{1'b1, arf, drf, m_time}); pushes++; end
      else dropped++;
    end
    m_level = m_level - (pop ? 1 : 0) + pushes;
    if (dropped > 0) m_ovf = 1'b1;
    m_drops = m_drops + dropped;
    if (m_drops > (2**CNT_W) - 1) m_drops = (2**CNT_W) - 1;
    if (hlt) m_frozen = 1'b1;

    @(posedge clk);
    #1;
    m_time++;
    chk("level", trace_level, m_level);
    chk("valid", trace_valid, m_level > 0);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drops);
    chk("frozen", frozen, m_frozen);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, 1'b0, '0, '0, rdy, 1'b1, m_frozen);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4 && m_level > 0; i++) idle(1'b1);
    chk("drained_level", trace_level, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    wren_dm = 1'b0; wren_rf = 1'b0; trace_ready = 1'b0; halt = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", trace_valid, 0);
    chk("rst_level", trace_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drops", drop_count, 0);
    chk("rst_frozen", frozen, 0);
    chk("rst_kind", trace_kind, 0);
    chk("rst_addr", trace_address, 0);
    chk("rst_data", trace_data, 0);
    exp_q.delete();
    m_level = 0; m_prev_dm = 0; m_prev_rf = 0; m_frozen = 0; m_ovf = 0;
    m_drops = 0; m_time = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single store held for 4 cycles yields one record.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("single_kind", trace_kind, 0);
    chk("single_addr", trace_address, 32'h100);
    chk("single_data", trace_data, 32'hDEADBEEF);
    idle(1'b0);
    chk("single_level", trace_level, 1);
    drain();

    // Simultaneous DM and RF: DM first, then RF.
    step(1'b1, 32'h10, 32'h1, 1'b1, 32'h3, 32'h2, 1'b0, 1'b1, 1'b0);
    chk("pair_level", trace_level, 2);
    chk("pair_head_kind", trace_kind, 0);
    drain();

    // Overflow: 18 RF events with no reads, then full FIFO pop+push.
    for (int i = 0; i < 18; i++) begin
      step(1'b0, '0, '0, 1'b1, i, 32'hA000 + i, 1'b0, 1'b1, 1'b0);
      idle(1'b0);
    end
    chk("ovf_level", trace_level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 2);
    step(1'b0, '0, '0, 1'b1, 32'h55, 32'h66, 1'b1, 1'b1, 1'b0);
    chk("fullpp_level", trace_level, 16);
    chk("fullpp_drops", drop_count, 2);
    idle(1'b0);
    // Simultaneous pair into a FIFO with one free slot after a pop.
    step(1'b1, 32'h77, 32'h88, 1'b1, 32'h99, 32'hAA, 1'b1, 1'b1, 1'b0);
    chk("onefree_drops", drop_count, 3);
    drain();

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1), $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 9) != 0, 1'b0);
    drain();

    // Reset mid-operation with 5 records queued.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h200 + i, i, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      idle(1'b0);
    end
    chk("pre_reset_level", trace_level, 5);
    do_reset();
    step(1'b0, '0, '0, 1'b1, 32'h7, 32'h1234, 1'b0, 1'b1, 1'b0);
    chk("post_reset_kind", trace_kind, 1);
    chk("post_reset_addr", trace_address, 32'h7);
    drain();

    // Halt freeze: event in the halt cycle is kept, later ones are ignored.
    step(1'b1, 32'h300, 32'h1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    step(1'b1, 32'h301, 32'h2, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h310 + i, i, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    end
    chk("halt_level", trace_level, 2);
    chk("halt_frozen", frozen, 1);
    chk("halt_drops", drop_count, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
